// File: rtl/qdec_cabac_reg_master_if.sv
// Register request/response bus between the CABAC register master and responder.
//
// Handshake: a request is presented by holding req_valid high with req_write,
// req_addr and req_wdata stable; it is accepted in the cycle where
// req_valid & req_ready are both high, and req_valid drops the following cycle.
// Only one request is outstanding at a time. The responder answers with a
// single-cycle resp_valid strobe (with resp_rdata / resp_err) no earlier than
// the cycle after acceptance.
interface qdec_cabac_reg_master_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/qdec_cabac_reg_master.sv
// Programs the CABAC control registers from parsed header words: writes
// VPS_0, SPS_0, SPS_1, PPS_0, SLICE_HEADER_0 in order, optionally reads each
// back and compares under its writable mask, then writes CABAC_START=1.
module qdec_cabac_reg_master #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] ADDR_VPS_0  = ADDR_W'(16'h0004),
    parameter logic [ADDR_W-1:0] ADDR_SPS_0  = ADDR_W'(16'h0008),
    parameter logic [ADDR_W-1:0] ADDR_SPS_1  = ADDR_W'(16'h000C),
    parameter logic [ADDR_W-1:0] ADDR_PPS_0  = ADDR_W'(16'h0010),
    parameter logic [ADDR_W-1:0] ADDR_SH_0   = ADDR_W'(16'h0014),
    parameter logic [ADDR_W-1:0] ADDR_START  = ADDR_W'(16'h0000),
    parameter logic [31:0]       MASK_VPS_0  = 32'h0000000f,
    parameter logic [31:0]       MASK_SPS_0  = 32'h0fffffff,
    parameter logic [31:0]       MASK_SPS_1  = 32'h07ffffff,
    parameter logic [31:0]       MASK_PPS_0  = 32'h0000ffff,
    parameter logic [31:0]       MASK_SH_0   = 32'h0000ffff,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        verify_en,
    input  logic [31:0] vps_0,
    input  logic [31:0] sps_0,
    input  logic [31:0] sps_1,
    input  logic [31:0] pps_0,
    input  logic [31:0] sh_0,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [2:0]  err_idx,
    output logic [3:0]  state_dbg,
    qdec_cabac_reg_master_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WR_REQ = 4'd1,
        S_WR_RSP = 4'd2,
        S_RD_REQ = 4'd3,
        S_RD_RSP = 4'd4,
        S_NEXT   = 4'd5,
        S_ST_REQ = 4'd6,
        S_ST_RSP = 4'd7,
        S_DONE   = 4'd8,
        S_ERR    = 4'd9
    } state_t;

    // Counter value at which the next cycle would reach TIMEOUT_CYC.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            state_d;
    logic [1:0]        code_d;
    logic [2:0]        idx;
    logic [7:0]        tcnt;
    logic              verify_q;
    logic [31:0]       vps_q, sps0_q, sps1_q, pps_q, sh_q;
    logic [31:0]       cur_word;
    logic [ADDR_W-1:0] cur_addr;
    logic              waiting;
    logic              accepted;
    logic              to_hit;

    assign waiting  = (state == S_WR_REQ) || (state == S_WR_RSP) ||
                      (state == S_RD_REQ) || (state == S_RD_RSP) ||
                      (state == S_ST_REQ) || (state == S_ST_RSP);
    assign accepted = bus.req_valid & bus.req_ready;
    assign to_hit   = (tcnt == TO_LAST);

    // Select the masked field word and register address for the current index.
    always_comb begin
        cur_word = 32'h0;
        cur_addr = '0;
        case (idx)
            3'd0: begin cur_word = vps_q;  cur_addr = ADDR_VPS_0; end
            3'd1: begin cur_word = sps0_q; cur_addr = ADDR_SPS_0; end
            3'd2: begin cur_word = sps1_q; cur_addr = ADDR_SPS_1; end
            3'd3: begin cur_word = pps_q;  cur_addr = ADDR_PPS_0; end
            3'd4: begin cur_word = sh_q;   cur_addr = ADDR_SH_0;  end
            default: begin cur_word = 32'h0; cur_addr = '0; end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state logic; a response arriving on the timeout cycle takes priority.
    always_comb begin
        state_d = state;
        code_d  = 2'd0;
        case (state)
            S_IDLE: if (go) state_d = S_WR_REQ;
            S_WR_REQ: begin
                if (accepted)    state_d = S_WR_RSP;
                else if (to_hit) begin state_d = S_ERR; code_d = 2'd1; end
            end
            S_WR_RSP: begin
                if (bus.resp_valid) begin
                    if (bus.resp_err) begin state_d = S_ERR; code_d = 2'd2; end
                    else if (verify_q) state_d = S_RD_REQ;
                    else               state_d = S_NEXT;
                end else if (to_hit) begin
                    state_d = S_ERR; code_d = 2'd1;
                end
            end
            S_RD_REQ: begin
                if (accepted)    state_d = S_RD_RSP;
                else if (to_hit) begin state_d = S_ERR; code_d = 2'd1; end
            end
            S_RD_RSP: begin
                if (bus.resp_valid) begin
                    if (bus.resp_err) begin state_d = S_ERR; code_d = 2'd2; end
                    else if (bus.resp_rdata != cur_word) begin
                        state_d = S_ERR; code_d = 2'd3;
                    end else state_d = S_NEXT;
                end else if (to_hit) begin
                    state_d = S_ERR; code_d = 2'd1;
                end
            end
            S_NEXT: state_d = (idx == 3'd4) ? S_ST_REQ : S_WR_REQ;
            S_ST_REQ: begin
                if (accepted)    state_d = S_ST_RSP;
                else if (to_hit) begin state_d = S_ERR; code_d = 2'd1; end
            end
            S_ST_RSP: begin
                if (bus.resp_valid) begin
                    if (bus.resp_err) begin state_d = S_ERR; code_d = 2'd2; end
                    else              state_d = S_DONE;
                end else if (to_hit) begin
                    state_d = S_ERR; code_d = 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Field capture, access index, error reporting and the wait-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= 3'd0;
            tcnt     <= 8'd0;
            verify_q <= 1'b0;
            vps_q    <= 32'h0;
            sps0_q   <= 32'h0;
            sps1_q   <= 32'h0;
            pps_q    <= 32'h0;
            sh_q     <= 32'h0;
            err_code <= 2'd0;
            err_idx  <= 3'd0;
        end else begin
            if (state == S_IDLE && go) begin
                vps_q    <= vps_0 & MASK_VPS_0;
                sps0_q   <= sps_0 & MASK_SPS_0;
                sps1_q   <= sps_1 & MASK_SPS_1;
                pps_q    <= pps_0 & MASK_PPS_0;
                sh_q     <= sh_0  & MASK_SH_0;
                verify_q <= verify_en;
                idx      <= 3'd0;
                err_code <= 2'd0;
                err_idx  <= 3'd0;
            end
            // Index 5 denotes the START access.
            if (state == S_NEXT) idx <= (idx == 3'd4) ? 3'd5 : idx + 3'd1;
            if (state_d == S_ERR && state != S_ERR) begin
                err_code <= code_d;
                err_idx  <= idx;
            end
            // Restart on every state change; saturate rather than wrap.
            if (state_d != state)                tcnt <= 8'd0;
            else if (waiting && tcnt != 8'hFF)   tcnt <= tcnt + 8'd1;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        err           = (state == S_ERR);
        state_dbg     = state;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = 32'h0;
        case (state)
            S_WR_REQ: begin
                bus.req_valid = 1'b1;
                bus.req_write = 1'b1;
                bus.req_addr  = cur_addr;
                bus.req_wdata = cur_word;
            end
            S_RD_REQ: begin
                bus.req_valid = 1'b1;
                bus.req_addr  = cur_addr;
            end
            S_ST_REQ: begin
                bus.req_valid = 1'b1;
                bus.req_write = 1'b1;
                bus.req_addr  = ADDR_START;
                bus.req_wdata = 32'h1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qdec_cabac_reg_master.sv
// Bench for qdec_cabac_reg_master: a responder model with a register memory,
// a scoreboard of expected bus requests, and directed sequence scenarios.
module tb_qdec_cabac_reg_master;

    localparam int ADDR_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        verify_en = 1'b0;
    logic [31:0] vps_0 = 32'h0, sps_0 = 32'h0, sps_1 = 32'h0, pps_0 = 32'h0, sh_0 = 32'h0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [2:0]  err_idx;
    logic [3:0]  state_dbg;

    qdec_cabac_reg_master_if #(.ADDR_W(ADDR_W)) bus ();

    qdec_cabac_reg_master #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .verify_en (verify_en),
        .vps_0     (vps_0),
        .sps_0     (sps_0),
        .sps_1     (sps_1),
        .pps_0     (pps_0),
        .sh_0      (sh_0),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .err_idx   (err_idx),
        .state_dbg (state_dbg),
        .bus       (bus)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard and reference tables ----------------
    // entry = {write, addr[15:0], wdata[31:0]}; reads carry wdata 0
    logic [48:0] exp_q[$];
    logic [15:0] addr_tab [6];
    logic [31:0] mask_tab [5];
    logic [31:0] f [5];

    // fault_kind: 0 none, 1 resp_err on write fault_idx, 2 no response to
    // write fault_idx, 3 corrupted readback at fault_idx
    int fault_kind = 0;
    int fault_idx  = 0;
    int stall_from = -1000;

    function automatic int addr_to_idx(input logic [15:0] a);
        for (int i = 0; i < 6; i++) if (addr_tab[i] == a) return i;
        return 7;
    endfunction

    task automatic build_exp(input bit v);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b1, addr_tab[i], f[i] & mask_tab[i]});
            if ((fault_kind == 1 || fault_kind == 2) && fault_idx == i) return;
            if (v) begin
                exp_q.push_back({1'b0, addr_tab[i], 32'h0});
                if (fault_kind == 3 && fault_idx == i) return;
            end
        end
        exp_q.push_back({1'b1, 16'h0000, 32'h1});
    endtask

    task automatic set_fields(input logic [31:0] a, b, c, d, e);
        f[0] = a; f[1] = b; f[2] = c; f[3] = d; f[4] = e;
        vps_0 = a; sps_0 = b; sps_1 = c; pps_0 = d; sh_0 = e;
    endtask

    // ---------------- responder model ----------------
    logic [31:0] mem [logic [15:0]];
    int          n_wr = 0, n_rd = 0, n_stall = 0;
    int          t_noresp = 0;
    logic        r_acc, r_prev_stall;
    logic [48:0] r_got, r_prev, r_cur;
    int          r_tneg, r_idx;
    logic [31:0] r_data;

    initial begin
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        r_prev_stall   = 1'b0;
        r_prev         = '0;
        forever begin
            @(negedge clk);
            r_tneg = cyc;
            r_acc  = bus.req_valid && bus.req_ready;
            r_cur  = {bus.req_write, bus.req_addr, bus.req_wdata};
            r_got  = {bus.req_write, bus.req_addr, bus.req_write ? bus.req_wdata : 32'h0};
            if (bus.req_valid && !bus.req_ready) begin
                n_stall++;
                if (r_prev_stall) check("req_stable", 64'(r_cur), 64'(r_prev));
                r_prev_stall = 1'b1;
                r_prev       = r_cur;
            end else begin
                r_prev_stall = 1'b0;
            end
            @(posedge clk);
            #1;
            bus.resp_valid = 1'b0;
            bus.resp_err   = 1'b0;
            bus.resp_rdata = 32'h0;
            if (rst) begin
                bus.req_ready = 1'b1;
            end else begin
                if (r_acc) begin
                    if (exp_q.size() == 0) check("sb_extra_req", 64'(r_got), 64'h0);
                    else                   check("sb_req", 64'(r_got), 64'(exp_q.pop_front()));
                    r_idx = addr_to_idx(r_got[47:32]);
                    if (r_got[48]) begin
                        n_wr++;
                        mem[r_got[47:32]] = (r_idx < 5) ? (r_got[31:0] & mask_tab[r_idx]) : r_got[31:0];
                        if (fault_kind == 2 && fault_idx == r_idx) begin
                            t_noresp = r_tneg;
                        end else begin
                            bus.resp_valid = 1'b1;
                            bus.resp_err   = (fault_kind == 1 && fault_idx == r_idx);
                        end
                    end else begin
                        n_rd++;
                        r_data = mem.exists(r_got[47:32]) ? mem[r_got[47:32]] : 32'h0;
                        if (fault_kind == 3 && fault_idx == r_idx) r_data = r_data | 32'h0800_0000;
                        bus.resp_valid = 1'b1;
                        bus.resp_rdata = r_data;
                    end
                end
                bus.req_ready = !(cyc >= stall_from && cyc < stall_from + 10);
            end
        end
    end

    // ---------------- sequence driver / monitor ----------------
    int nd, ne, lc, li, t_err, w0, r0, s0;

    task automatic run_seq(input bit vflag, input int regos_at, input bit stall);
        bit finished;
        nd = 0; ne = 0; lc = 0; li = 0; t_err = 0;
        w0 = n_wr; r0 = n_rd; s0 = n_stall;
        build_exp(vflag);
        @(negedge clk);
        verify_en = vflag;
        go = 1'b1;
        if (stall) stall_from = cyc + 1;
        @(negedge clk);
        go = 1'b0;
        verify_en = ~vflag;
        finished = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            go = (k == regos_at);
            if (k == regos_at) begin
                vps_0 = $urandom; sps_0 = $urandom; sps_1 = $urandom;
                pps_0 = $urandom; sh_0 = $urandom;
            end
            if (done) nd++;
            if (err) begin
                ne++;
                lc = int'(err_code);
                li = int'(err_idx);
                t_err = cyc;
                check("req_valid_in_err", 64'(bus.req_valid), 64'd0);
            end
            if ((nd + ne) > 0 && !busy) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        go = 1'b0;
        check("seq_finished", 64'(finished), 64'd1);
        check("sb_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic rand_fields(input logic [31:0] first);
        set_fields(first, $urandom, $urandom, $urandom, $urandom);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        addr_tab[0] = 16'h0004; addr_tab[1] = 16'h0008; addr_tab[2] = 16'h000C;
        addr_tab[3] = 16'h0010; addr_tab[4] = 16'h0014; addr_tab[5] = 16'h0000;
        mask_tab[0] = 32'h0000000f; mask_tab[1] = 32'h0fffffff; mask_tab[2] = 32'h07ffffff;
        mask_tab[3] = 32'h0000ffff; mask_tab[4] = 32'h0000ffff;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 64'({busy, done, err, err_code, err_idx, bus.req_valid,
                                  bus.req_write, bus.req_addr, bus.req_wdata}), 64'h0);
        check("rst_state", 64'(state_dbg), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // plain write sequence, vps_0 all ones
        fault_kind = 0;
        rand_fields(32'hFFFF_FFFF);
        run_seq(1'b0, -1, 1'b0);
        check("t1_done", 64'(nd), 64'd1);
        check("t1_err", 64'(ne), 64'd0);
        check("t1_writes", 64'(n_wr - w0), 64'd6);
        check("t1_reads", 64'(n_rd - r0), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);

        // verify with echoing responder
        rand_fields($urandom);
        run_seq(1'b1, -1, 1'b0);
        check("t2_done", 64'(nd), 64'd1);
        check("t2_err", 64'(ne), 64'd0);
        check("t2_writes", 64'(n_wr - w0), 64'd6);
        check("t2_reads", 64'(n_rd - r0), 64'd5);

        // corrupted sps_1 readback
        fault_kind = 3; fault_idx = 2;
        rand_fields($urandom);
        run_seq(1'b1, -1, 1'b0);
        check("t3_err", 64'(ne), 64'd1);
        check("t3_done", 64'(nd), 64'd0);
        check("t3_code", 64'(lc), 64'd3);
        check("t3_idx", 64'(li), 64'd2);
        check("t3_writes", 64'(n_wr - w0), 64'd3);
        repeat (4) @(negedge clk);
        check("t3_code_held", 64'(err_code), 64'd3);
        check("t3_idx_held", 64'(err_idx), 64'd2);

        // bus error on the PPS_0 write
        fault_kind = 1; fault_idx = 3;
        rand_fields($urandom);
        run_seq(1'b0, -1, 1'b0);
        check("t4_err", 64'(ne), 64'd1);
        check("t4_code", 64'(lc), 64'd2);
        check("t4_idx", 64'(li), 64'd3);
        check("t4_writes", 64'(n_wr - w0), 64'd4);

        // no response to the SH_0 write
        fault_kind = 2; fault_idx = 4;
        rand_fields($urandom);
        run_seq(1'b0, -1, 1'b0);
        check("t5_err", 64'(ne), 64'd1);
        check("t5_code", 64'(lc), 64'd1);
        check("t5_idx", 64'(li), 64'd4);
        check("t5_latency", 64'(t_err - t_noresp), 64'd256);

        // ready held low for 10 cycles at the first request
        fault_kind = 0;
        rand_fields($urandom);
        run_seq(1'b1, -1, 1'b1);
        stall_from = -1000;
        check("t6_done", 64'(nd), 64'd1);
        check("t6_stall_cycles", 64'(n_stall - s0), 64'd10);
        check("t6_code_cleared", 64'(err_code), 64'd0);

        // go while busy is ignored
        rand_fields($urandom);
        run_seq(1'b0, 3, 1'b0);
        check("t7_done", 64'(nd), 64'd1);
        check("t7_err", 64'(ne), 64'd0);
        check("t7_writes", 64'(n_wr - w0), 64'd6);

        // reset in the middle of a sequence, then restart
        rand_fields($urandom);
        build_exp(1'b1);
        @(negedge clk);
        verify_en = 1'b1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t8_rst_outputs", 64'({busy, done, err, err_code, err_idx, bus.req_valid,
                                     bus.req_write, bus.req_addr, bus.req_wdata}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            check("t8_quiet", 64'({busy, done, err}), 64'h0);
            @(negedge clk);
        end
        rand_fields($urandom);
        run_seq(1'b0, -1, 1'b0);
        check("t8_restart_done", 64'(nd), 64'd1);
        check("t8_restart_writes", 64'(n_wr - w0), 64'd6);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/qdec_cabac_reg_master.md
Name: qdec_cabac_reg_master

Overview:
- Register-bus initiator that programs the CABAC control register block from parsed header fields.
- On a `go` pulse it writes five registers in order: VPS_0, SPS_0, SPS_1, PPS_0, SLICE_HEADER_0.
- Optionally reads each one back and checks it under its mask, then writes CABAC_START=1.
- Sits between the header parser and the CABAC register responder; it is the requester end of the same reg_req/reg_resp protocol.

Parameters:
- ADDR_W, 16, register address width
- ADDR_VPS_0 / ADDR_SPS_0 / ADDR_SPS_1 / ADDR_PPS_0 / ADDR_SH_0 / ADDR_START, 16'h0004/0008/000C/0010/0014/0000, register addresses
- MASK_VPS_0 / MASK_SPS_0 / MASK_SPS_1 / MASK_PPS_0 / MASK_SH_0, 32'h0000000f/0fffffff/07ffffff/0000ffff/0000ffff, writable-bit masks
- TIMEOUT_CYC, 255, maximum number of cycles spent waiting for a response

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- go  in  1  one-cycle pulse; starts a programming sequence (ignored unless idle)
- verify_en  in  1  sampled on go; 1 = read back after each write
- vps_0 / sps_0 / sps_1 / pps_0 / sh_0  in  32 each  field words; captured on accepted go
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on success
- err  out  1  one-cycle pulse on failure
- err_code  out  2  1 = timeout, 2 = bus error, 3 = readback mismatch; held until next go
- err_idx  out  3  index of the failing access, 0..5 (5 = START); held until next go
- req_valid  out  1  request valid
- req_ready  in  1  responder accepts the request
- req_write  out  1  1 = write, 0 = read
- req_addr  out  ADDR_W  request address
- req_wdata  out  32  write data
- resp_valid  in  1  one-cycle response strobe
- resp_rdata  in  32  read data
- resp_err  in  1  responder error (e.g. bad address)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, idx=0, timeout counter=0; all outputs 0. This includes req_valid, busy, done, err, err_code, err_idx, req_write, req_addr and req_wdata.
- Reset mid-sequence aborts at once, with no done or err pulse.
- Bus rules:
  - Only one request is outstanding at a time.
  - req_valid rises and stays high, with addr/data/write stable, until the cycle where req_valid & req_ready.
  - The request is accepted in that cycle and req_valid drops the next cycle.
  - A response is accepted only in a *_RSP state. resp_valid in any other state is ignored.
  - resp_valid in the same cycle as acceptance is not legal and is ignored.
- Capture: go in IDLE latches all five field words and verify_en, sets busy=1 the next cycle and enters WR_REQ with idx=0.
  - go while busy is ignored.
- Write data is the field word AND its mask; the address comes from the idx table.
- States and transitions:
  - IDLE: go -> WR_REQ.
  - WR_REQ: accepted -> WR_RSP.
  - WR_RSP:
    - resp_valid & resp_err -> ERR (code 2).
    - resp_valid & verify -> RD_REQ.
    - resp_valid & !verify -> NEXT.
  - RD_REQ: accepted -> RD_RSP.
  - RD_RSP:
    - resp_valid & resp_err -> ERR (code 2).
    - resp_valid & rdata != (field & mask) -> ERR (code 3).
    - otherwise -> NEXT.
  - NEXT: idx==4 -> ST_REQ. Otherwise idx++ -> WR_REQ. NEXT is a single-cycle state.
  - ST_REQ: write ADDR_START, wdata=32'h1, idx=5; accepted -> ST_RSP.
  - ST_RSP: resp_valid -> DONE, or ERR (code 2) if resp_err. START is never read back.
  - DONE: done=1 for one cycle; busy=0 next cycle -> IDLE.
  - ERR: err=1 for one cycle; err_code/err_idx are set; req_valid is forced 0; busy=0 next cycle -> IDLE.
- Timeout:
  - An 8-bit counter clears on entering any *_REQ or *_RSP state and increments each cycle while there.
  - Reaching TIMEOUT_CYC -> ERR (code 1), err_idx=idx.
  - The counter saturates and never wraps.
- A resp_valid that arrives in the same cycle the counter reaches TIMEOUT_CYC wins: the response is processed and no timeout is raised.
- Nominal latency with ready and response both immediate: each access takes 2 cycles (REQ then RSP) if resp_valid comes the cycle after acceptance.

Test Plan:
- verify_en=0, ready=1, response 1 cycle after accept, vps_0=32'hFFFFFFFF:
  - First write has addr 0x0004, wdata 32'h0000000F.
  - 6 writes total; last write is addr 0x0000, wdata 1.
  - done pulses once; busy=0 afterwards.
- verify_en=1, the responder model echoes masked data: expect 5 writes, 5 reads and 1 START, in the order W/R per index; done=1, err never asserted.
- verify_en=1, the model returns sps_1 readback with bit 27 set: err=1, err_code=3, err_idx=2; no START write issued.
- resp_err=1 on the PPS_0 write: err_code=2, err_idx=3; req_valid=0 from the ERR cycle on.
- No response to the SH_0 write: err asserts 255 cycles after entering WR_RSP, err_code=1, err_idx=4.
- req_ready held low for 10 cycles: req_valid, req_addr and req_wdata are stable throughout.
- go pulsed while busy: ignored.
- rst asserted mid-sequence: all outputs 0 the next cycle, and a new go restarts at idx 0.
